// File: rtl/itch_msg_aligner.sv
// Gathers one fixed-length message from a BUS_BYTES-wide beat stream that may start at any byte offset.
// It presents the message realigned to byte 0 and reports where the next message begins in the shared beat.
module itch_msg_aligner #(
  parameter int BUS_BYTES = 8,
  parameter int MSG_BYTES = 45,
  parameter int OFF_W     = $clog2(BUS_BYTES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [BUS_BYTES*8-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   start,
  input  logic [OFF_W-1:0]       start_offset,
  input  logic                   abort,
  output logic                   end_valid,
  output logic [OFF_W-1:0]       end_offset,
  output logic                   end_consumed,
  output logic [MSG_BYTES*8-1:0] msg_data,
  output logic                   msg_valid,
  input  logic                   msg_ready
);

  localparam int CW = OFF_W + $clog2(MSG_BYTES) + 1;
  localparam logic [CW-1:0] BUS_C = CW'(BUS_BYTES);
  localparam logic [CW-1:0] MSG_C = CW'(MSG_BYTES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t                 state_r;
  state_t                 stateNext_s;
  logic [CW-1:0]          count_r;
  logic [CW-1:0]          countNext_s;
  logic [CW-1:0]          base_s;
  logic [CW-1:0]          writeBase_s;
  logic [CW-1:0]          avail_s;
  logic [CW-1:0]          remain_s;
  logic [CW-1:0]          take_s;
  logic [CW-1:0]          endIdx_s;
  logic [OFF_W-1:0]       srcOff_s;
  logic                   inWin_s;
  logic                   accept_s;
  logic                   load_s;
  logic                   done_s;
  logic [MSG_BYTES*8-1:0] msgData_r;
  logic [MSG_BYTES*8-1:0] msgBase_s;
  logic [MSG_BYTES*8-1:0] msgNext_s;

  // Window arithmetic: which beat bytes land where in the message, and whether this beat finishes it.
  // The first beat reads from start_offset into message byte 0; later beats read from byte 0 into count.
  always_comb begin
    accept_s = in_valid && (state_r != HOLD);
    if (state_r == IDLE) begin
      base_s      = CW'(start_offset);
      writeBase_s = {CW{1'b0}};
    end else begin
      base_s      = {CW{1'b0}};
      writeBase_s = count_r;
    end
    avail_s  = BUS_C - base_s;
    remain_s = MSG_C - writeBase_s;
    if (avail_s < remain_s) begin
      take_s = avail_s;
    end else begin
      take_s = remain_s;
    end
    endIdx_s    = base_s + take_s;
    countNext_s = writeBase_s + take_s;
    case (state_r)
      IDLE:    load_s = accept_s && start && !abort;
      COLLECT: load_s = accept_s && !abort;
      default: load_s = 1'b0;
    endcase
    done_s = load_s && (countNext_s == MSG_C) && !rst;
  end

  // Merge the accepted beat into the message image; a new message starts from a cleared image.
  always_comb begin
    msgBase_s = (state_r == IDLE) ? {(MSG_BYTES*8){1'b0}} : msgData_r;
    msgNext_s = msgBase_s;
    srcOff_s  = {OFF_W{1'b0}};
    inWin_s   = 1'b0;
    for (int k = 0; k < MSG_BYTES; k++) begin
      srcOff_s = OFF_W'(CW'(k) - writeBase_s + base_s);
      inWin_s  = (CW'(k) >= writeBase_s) && (CW'(k) < countNext_s);
      msgNext_s[8*k +: 8] = inWin_s ? in_data[8*srcOff_s +: 8] : msgBase_s[8*k +: 8];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // Next-state logic; abort outranks completion, and HOLD waits for the consumer.
  always_comb begin
    stateNext_s = state_r;
    case (state_r)
      IDLE: begin
        if (load_s) begin
          stateNext_s = done_s ? HOLD : COLLECT;
        end else begin
          stateNext_s = IDLE;
        end
      end
      COLLECT: begin
        if (abort) begin
          stateNext_s = IDLE;
        end else if (done_s) begin
          stateNext_s = HOLD;
        end else begin
          stateNext_s = COLLECT;
        end
      end
      HOLD: begin
        if (msg_ready) begin
          stateNext_s = IDLE;
        end else begin
          stateNext_s = HOLD;
        end
      end
      default: stateNext_s = IDLE;
    endcase
  end

  // Byte count and message image.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r   <= {CW{1'b0}};
      msgData_r <= {(MSG_BYTES*8){1'b0}};
    end else if (load_s) begin
      count_r   <= countNext_s;
      msgData_r <= msgNext_s;
    end else if ((state_r == COLLECT) && abort) begin
      count_r   <= {CW{1'b0}};
      msgData_r <= msgData_r;
    end else if ((state_r == HOLD) && msg_ready) begin
      count_r   <= {CW{1'b0}};
      msgData_r <= msgData_r;
    end else begin
      count_r   <= count_r;
      msgData_r <= msgData_r;
    end
  end

  assign in_ready     = (state_r != HOLD);
  assign msg_valid    = (state_r == HOLD);
  assign msg_data     = msgData_r;
  assign end_valid    = done_s;
  assign end_offset   = done_s ? endIdx_s[OFF_W-1:0] : {OFF_W{1'b0}};
  assign end_consumed = done_s && (endIdx_s == BUS_C);

endmodule

// File: tb/tb_itch_msg_aligner.sv
// Self-checking bench for itch_msg_aligner: directed cases plus randomized messages against a byte-stream model.
module tb_itch_msg_aligner;

  localparam int BB = 8;
  localparam int MB = 45;
  localparam int OW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [BB*8-1:0] in_data;
  logic            in_valid;
  logic            in_ready;
  logic            start;
  logic [OW-1:0]   start_offset;
  logic            abort;
  logic            end_valid;
  logic [OW-1:0]   end_offset;
  logic            end_consumed;
  logic [MB*8-1:0] msg_data;
  logic            msg_valid;
  logic            msg_ready;

  logic [BB*8-1:0] in4Data;
  logic            in4Valid;
  logic            in4Ready;
  logic            start4;
  logic [OW-1:0]   start4Offset;
  logic            abort4;
  logic            end4Valid;
  logic [OW-1:0]   end4Offset;
  logic            end4Consumed;
  logic [31:0]     msg4Data;
  logic            msg4Valid;
  logic            msg4Ready;

  int nChecks = 0;
  int nFails  = 0;
  byte unsigned stream [64];

  itch_msg_aligner #(.BUS_BYTES(BB), .MSG_BYTES(MB)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .start(start), .start_offset(start_offset), .abort(abort), .end_valid(end_valid),
    .end_offset(end_offset), .end_consumed(end_consumed), .msg_data(msg_data),
    .msg_valid(msg_valid), .msg_ready(msg_ready)
  );

  itch_msg_aligner #(.BUS_BYTES(BB), .MSG_BYTES(4)) dut4 (
    .clk(clk), .rst(rst), .in_data(in4Data), .in_valid(in4Valid), .in_ready(in4Ready),
    .start(start4), .start_offset(start4Offset), .abort(abort4), .end_valid(end4Valid),
    .end_offset(end4Offset), .end_consumed(end4Consumed), .msg_data(msg4Data),
    .msg_valid(msg4Valid), .msg_ready(msg4Ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkMsg(input string tag, input logic [MB*8-1:0] obs, input logic [MB*8-1:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic driveBeat(input int b, input logic st, input logic [OW-1:0] off);
    in_valid     = 1'b1;
    start        = st;
    start_offset = off;
    for (int i = 0; i < BB; i++) in_data[8*i +: 8] = stream[b*BB + i];
  endtask

  // Model: the message is bytes off..off+MB-1 of the concatenated beat stream.
  task automatic runMsg(input int off, input bit seqData, input int gapMax, input int holdCycles,
                        input string tag);
    int nBeats;
    int endIdx;
    int gaps;
    logic [MB*8-1:0] expMsg;
    nBeats = (off + MB + BB - 1) / BB;
    for (int j = 0; j < 64; j++) stream[j] = seqData ? 8'(j) : 8'($urandom_range(0, 255));
    for (int k = 0; k < MB; k++) expMsg[8*k +: 8] = stream[off + k];
    endIdx = off + MB - (nBeats - 1) * BB;
    for (int b = 0; b < nBeats; b++) begin
      gaps = (b > 0) ? $urandom_range(0, gapMax) : 0;
      for (int g = 0; g < gaps; g++) begin
        in_valid     = 1'b0;
        start        = 1'($urandom_range(0, 1));
        start_offset = OW'($urandom_range(0, BB - 1));
        @(negedge clk);
        chk({tag, " gap end_valid"}, 32'(end_valid), 32'(0));
        cycle();
      end
      driveBeat(b, (b == 0) ? 1'b1 : 1'($urandom_range(0, 1)),
                (b == 0) ? OW'(off) : OW'($urandom_range(0, BB - 1)));
      @(negedge clk);
      chk({tag, " in_ready"}, 32'(in_ready), 32'(1));
      chk({tag, " end_valid"}, 32'(end_valid), 32'(b == nBeats - 1));
      if (b == nBeats - 1) begin
        chk({tag, " end_offset"}, 32'(end_offset), endIdx % BB);
        chk({tag, " end_consumed"}, 32'(end_consumed), 32'(endIdx == BB));
      end else begin
        chk({tag, " msg_valid early"}, 32'(msg_valid), 32'(0));
      end
      cycle();
    end
    in_valid = 1'b0;
    start    = 1'b0;
    chk({tag, " msg_valid"}, 32'(msg_valid), 32'(1));
    chk({tag, " hold in_ready"}, 32'(in_ready), 32'(0));
    chkMsg({tag, " msg_data"}, msg_data, expMsg);
    for (int h = 0; h < holdCycles; h++) begin
      cycle();
      chk({tag, " held msg_valid"}, 32'(msg_valid), 32'(1));
      chk({tag, " held in_ready"}, 32'(in_ready), 32'(0));
      chkMsg({tag, " held msg_data"}, msg_data, expMsg);
    end
    msg_ready = 1'b1;
    cycle();
    msg_ready = 1'b0;
    chk({tag, " drained msg_valid"}, 32'(msg_valid), 32'(0));
    chk({tag, " drained in_ready"}, 32'(in_ready), 32'(1));
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; start = 1'b0; start_offset = '0; abort = 1'b0;
    msg_ready = 1'b0;
    in4Data = '0; in4Valid = 1'b0; start4 = 1'b0; start4Offset = '0; abort4 = 1'b0; msg4Ready = 1'b0;
    cycle();
    cycle();
    chk("reset msg_valid", 32'(msg_valid), 32'(0));
    chk("reset end_valid", 32'(end_valid), 32'(0));
    chk("reset end_offset", 32'(end_offset), 32'(0));
    chk("reset end_consumed", 32'(end_consumed), 32'(0));
    chk("reset in_ready", 32'(in_ready), 32'(1));
    chkMsg("reset msg_data", msg_data, '0);
    rst = 1'b0;
    cycle();

    runMsg(0, 1'b1, 0, 0, "c1");
    runMsg(3, 1'b1, 0, 0, "c2");

    // Four-byte message completing inside its first beat.
    in4Data = 64'h0706050403020100; in4Valid = 1'b1; start4 = 1'b1; start4Offset = 3'd2;
    @(negedge clk);
    chk("c3 end_valid", 32'(end4Valid), 32'(1));
    chk("c3 end_offset", 32'(end4Offset), 32'(6));
    chk("c3 end_consumed", 32'(end4Consumed), 32'(0));
    cycle();
    in4Valid = 1'b0; start4 = 1'b0;
    chk("c3 msg_valid", 32'(msg4Valid), 32'(1));
    chk("c3 msg_data", msg4Data, 32'h05040302);
    msg4Ready = 1'b1;
    cycle();
    msg4Ready = 1'b0;
    chk("c3 drained", 32'(msg4Valid), 32'(0));

    runMsg(0, 1'b1, 0, 3, "c4");

    // Beat without start while idle is dropped.
    for (int j = 0; j < 64; j++) stream[j] = 8'(j);
    driveBeat(2, 1'b0, 3'd0);
    @(negedge clk);
    chk("drop end_valid", 32'(end_valid), 32'(0));
    cycle();
    in_valid = 1'b0;
    chk("drop msg_valid", 32'(msg_valid), 32'(0));

    // Abort after beat 2; the beat alongside the abort is not written.
    for (int b = 0; b < 3; b++) begin
      driveBeat(b, b == 0, 3'd0);
      cycle();
    end
    driveBeat(3, 1'b0, 3'd0);
    abort = 1'b1;
    @(negedge clk);
    chk("c5 abort end_valid", 32'(end_valid), 32'(0));
    cycle();
    abort = 1'b0; in_valid = 1'b0;
    chk("c5 abort msg_valid", 32'(msg_valid), 32'(0));
    chk("c5 abort in_ready", 32'(in_ready), 32'(1));
    runMsg(7, 1'b1, 0, 0, "c5");

    // Reset in the middle of collection.
    for (int b = 0; b < 2; b++) begin
      driveBeat(b, b == 0, 3'd0);
      cycle();
    end
    rst = 1'b1;
    for (int r = 0; r < 4; r++) begin
      in_valid = r[0];
      @(negedge clk);
      chk("c6 rst end_valid", 32'(end_valid), 32'(0));
      cycle();
      chk("c6 rst msg_valid", 32'(msg_valid), 32'(0));
      chk("c6 rst end_offset", 32'(end_offset), 32'(0));
      chk("c6 rst end_consumed", 32'(end_consumed), 32'(0));
      chkMsg("c6 rst msg_data", msg_data, '0);
    end
    rst = 1'b0; in_valid = 1'b0; start = 1'b0;
    cycle();
    runMsg(0, 1'b1, 0, 0, "c6");

    for (int t = 0; t < 20; t++) begin
      runMsg($urandom_range(0, BB - 1), 1'b0, 2, $urandom_range(0, 2), "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
